// File: rtl/hilo_muldiv_seq.sv
// HI/LO register owner with a multi-cycle multiply/divide engine for the execute stage.
// A multiply commits after MUL_STAGES cycles; a divide runs 32 restoring iterations plus one sign-fix cycle.
module hilo_muldiv_seq #(
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  funct,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 5;

  localparam logic [3:0] F_MULT  = 4'b1011;
  localparam logic [3:0] F_MULTU = 4'b1100;
  localparam logic [3:0] F_DIV   = 4'b1101;
  localparam logic [3:0] F_DIVU  = 4'b1110;

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(31);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q, b_q;
  logic          signed_q, dz_q, neg_quo_q, neg_rem_q;
  logic [W-1:0]  rem_q, quo_q, dvs_q;

  // request decode
  logic         funct_ok_c, is_mul_c, is_signed_c, accept_c;
  logic [W-1:0] abs1_c, abs2_c;

  always_comb begin
    funct_ok_c  = (funct == F_MULT) || (funct == F_MULTU) ||
                  (funct == F_DIV)  || (funct == F_DIVU);
    is_mul_c    = (funct == F_MULT) || (funct == F_MULTU);
    is_signed_c = (funct == F_MULT) || (funct == F_DIV);
    accept_c    = req_valid && (state == S_IDLE) && !flush && funct_ok_c;
    abs1_c      = (is_signed_c && in1[W-1]) ? (W'(0) - in1) : in1;
    abs2_c      = (is_signed_c && in2[W-1]) ? (W'(0) - in2) : in2;
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (is_mul_c)         state_nxt = S_MUL;
          else if (in2 == W'(0)) state_nxt = S_FIX;
          else                  state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        if (flush || (cnt == MUL_LAST)) state_nxt = S_IDLE;
      end
      S_DIV: begin
        if (flush)                  state_nxt = S_IDLE;
        else if (cnt == DIV_LAST)   state_nxt = S_FIX;
      end
      S_FIX: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath combinational: product, one restoring step, sign fix, commit value
  logic [DW-1:0] mul_a_c, mul_b_c, prod_c;
  logic [W:0]    shift_c, diff_c;
  logic          ge_c;
  logic [W-1:0]  rem_step_c, quo_step_c, quo_fix_c, rem_fix_c;
  logic          commit_c;
  logic [W-1:0]  res_hi_c, res_lo_c;

  always_comb begin
    mul_a_c    = {{W{signed_q & a_q[W-1]}}, a_q};
    mul_b_c    = {{W{signed_q & b_q[W-1]}}, b_q};
    prod_c     = mul_a_c * mul_b_c;
    shift_c    = {rem_q, quo_q[W-1]};
    diff_c     = shift_c - {1'b0, dvs_q};
    ge_c       = !diff_c[W];
    rem_step_c = ge_c ? diff_c[W-1:0] : shift_c[W-1:0];
    quo_step_c = {quo_q[W-2:0], ge_c};
    quo_fix_c  = neg_quo_q ? (W'(0) - quo_q) : quo_q;
    rem_fix_c  = neg_rem_q ? (W'(0) - rem_q) : rem_q;
  end

  // output logic: commit strobe and value
  always_comb begin
    commit_c = 1'b0;
    res_hi_c = hi;
    res_lo_c = lo;
    unique case (state)
      S_MUL: begin
        commit_c = !flush && (cnt == MUL_LAST);
        res_hi_c = prod_c[DW-1:W];
        res_lo_c = prod_c[W-1:0];
      end
      S_FIX: begin
        commit_c = !flush;
        res_hi_c = dz_q ? a_q : rem_fix_c;
        res_lo_c = dz_q ? {W{1'b1}} : quo_fix_c;
      end
      default: ;
    endcase
  end

  // iteration counter: restarts on every state change
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == S_MUL) || (state == S_DIV)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // operand latch and divider iteration registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
    end else if (accept_c) begin
      a_q       <= in1;
      b_q       <= in2;
      signed_q  <= is_signed_c;
      dz_q      <= !is_mul_c && (in2 == W'(0));
      neg_quo_q <= is_signed_c && (in1[W-1] ^ in2[W-1]);
      neg_rem_q <= is_signed_c && in1[W-1];
      rem_q     <= '0;
      quo_q     <= abs1_c;
      dvs_q     <= abs2_c;
    end else if (state == S_DIV) begin
      rem_q     <= rem_step_c;
      quo_q     <= quo_step_c;
    end
  end

  // HI/LO: commit wins; MTHI/MTLO only land while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (commit_c) begin
      hi <= res_hi_c;
      lo <= res_lo_c;
    end else if (state == S_IDLE) begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

  // status outputs track the next state so they equal the state decode each cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done      <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done      <= commit_c;
      busy      <= (state_nxt != S_IDLE);
      req_ready <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: expected HI/LO pairs queue up at launch and are
// checked when done pulses; reset, flush, MTHI/MTLO and back-to-back cases are checked inline.
module tb_hilo_muldiv_seq;

  localparam logic [3:0] F_MULT  = 4'b1011;
  localparam logic [3:0] F_MULTU = 4'b1100;
  localparam logic [3:0] F_DIV   = 4'b1101;
  localparam logic [3:0] F_DIVU  = 4'b1110;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [3:0]  funct;
  logic [31:0] in1, in2;
  logic        flush, wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int ncmp = 0;
  int nmis = 0;
  logic [63:0] sb_q[$];
  logic [31:0] cur_hi, cur_lo;

  hilo_muldiv_seq #(.MUL_STAGES(1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .funct(funct), .in1(in1), .in2(in2), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference results built from language arithmetic
  function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint la, lb;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    case (f)
      F_MULT:  return 64'(la * lb);
      F_MULTU: return {32'h0, a} * {32'h0, b};
      F_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      F_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  task automatic launch(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    sb_q.push_back(exp);
    req_valid = 1'b1; funct = f; in1 = a; in2 = b;
    step();
    req_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'(1));
  endtask

  // waits for done, checks the remaining latency and the committed HI/LO
  task automatic finish(input int lat);
    int n;
    logic [63:0] exp;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("done_latency", 64'(n), 64'(lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hX;
    chk("hi", 64'(hi), 64'(exp[63:32]));
    chk("lo", 64'(lo), 64'(exp[31:0]));
    chk("ready_at_done", 64'(req_ready), 64'(1));
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
    step();
    chk("done_one_cycle", 64'(done), 64'(0));
  endtask

  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat);
    launch(f, a, b, exp);
    finish(lat);
  endtask

  initial begin
    logic [3:0] rf;
    logic [31:0] ra, rb;

    resetn = 1'b0; req_valid = 1'b0; funct = 4'h0; in1 = '0; in2 = '0;
    flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'h0);
    #5 resetn = 1'b1;
    step();

    do_op(F_MULT,  32'hFFFF_FFFE, 32'h3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1);
    do_op(F_MULTU, 32'hFFFF_FFFE, 32'h3, {32'h0000_0002, 32'hFFFF_FFFA}, 1);
    do_op(F_DIV,   32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_op(F_DIVU,  32'h7, 32'h2, {32'h1, 32'h3}, 33);
    do_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    do_op(F_DIVU,  32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 1);
    do_op(F_DIV,   32'hFFFF_FF00, 32'h0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1);

    // unknown funct is ignored
    req_valid = 1'b1; funct = 4'h0; in1 = 32'h5; in2 = 32'h6;
    step();
    req_valid = 1'b0;
    chk("badfunct_busy", 64'(busy), 64'(0));
    chk("badfunct_hilo", {hi, lo}, {cur_hi, cur_lo});

    // MTHI alone, then both strobes together
    wr_hi = 1'b1; wr_data = 32'hA5A5_A5A5;
    step();
    wr_hi = 1'b0;
    chk("mthi", {hi, lo}, {32'hA5A5_A5A5, cur_lo});
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5A5A_0F0F;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h5A5A_0F0F, 32'h5A5A_0F0F});
    cur_hi = 32'h5A5A_0F0F; cur_lo = 32'h5A5A_0F0F;

    // flush at iteration 10 aborts the divide silently
    req_valid = 1'b1; funct = F_DIV; in1 = 32'd100; in2 = 32'd7;
    step();
    req_valid = 1'b0;
    repeat (10) step();
    chk("busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    step();
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_done", 64'(done), 64'(0));
    chk("flush_hilo", {hi, lo}, {cur_hi, cur_lo});
    req_valid = 1'b1; funct = F_MULT; in1 = 32'h9; in2 = 32'h9;
    step();
    chk("flush_blocks_accept", 64'(busy), 64'(0));
    req_valid = 1'b0; flush = 1'b0;
    step();
    chk("flush_no_late_done", 64'(done), 64'(0));
    chk("flush_hilo_after", {hi, lo}, {cur_hi, cur_lo});

    // MTLO while a divide is in flight is dropped
    launch(F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
    step();
    wr_lo = 1'b0;
    chk("mtlo_while_busy", 64'(lo), 64'(cur_lo));
    finish(32);

    // write and accept on the same edge: write lands, commit overwrites
    wr_hi = 1'b1; wr_data = 32'h1111_1111;
    launch(F_MULT, 32'h3, 32'h5, {32'h0, 32'hF});
    wr_hi = 1'b0;
    chk("write_at_accept", 64'(hi), 64'h1111_1111);
    finish(1);

    // back-to-back: second request held valid, accepted the cycle after the commit
    sb_q.push_back({32'h0, 32'h6});
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFC});
    req_valid = 1'b1; funct = F_MULTU; in1 = 32'h2; in2 = 32'h3;
    step();
    funct = F_MULT; in1 = 32'h4; in2 = 32'hFFFF_FFFF;
    step();
    chk("b2b_first_done", 64'(done), 64'(1));
    chk("b2b_first_hilo", {hi, lo}, sb_q.pop_front());
    chk("b2b_not_in_commit", 64'(req_ready), 64'(1));
    step();
    req_valid = 1'b0;
    chk("b2b_second_accepted", 64'(busy), 64'(1));
    step();
    chk("b2b_second_done", 64'(done), 64'(1));
    chk("b2b_second_hilo", {hi, lo}, sb_q.pop_front());
    cur_hi = hi; cur_lo = lo;
    step();

    // random operations against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(3))
        0: rf = F_MULT;
        1: rf = F_MULTU;
        2: rf = F_DIV;
        default: rf = F_DIVU;
      endcase
      ra = $urandom();
      rb = (i == 5) ? 32'h0 : (($urandom_range(1) == 1) ? $urandom() : 32'($urandom_range(200) + 1));
      do_op(rf, ra, rb, model(rf, ra, rb),
            ((rf == F_DIV || rf == F_DIVU) && rb != 32'h0) ? 33 : 1);
    end

    // asynchronous reset in the middle of a divide
    req_valid = 1'b1; funct = F_DIV; in1 = 32'd1000; in2 = 32'd3;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_ready", 64'(req_ready), 64'(1));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    #1 resetn = 1'b1;
    step();
    chk("after_rst_idle", 64'(busy), 64'(0));
    chk("after_rst_done", 64'(done), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
